ahb_lite_sram_slave: RTL and testbench

AHB-Lite slave with a word-organised internal memory, a configurable number of wait states and a two-cycle ERROR response. It is slave 1 of the bus. Its HRDATA_S, HREADYOUT and HRESP_S feed the slave-side inputs of the read-data/response multiplexer. It receives the multiplexer's HREADY output back as its HREADY input.

---
 rtl/ahb_lite_sram_slave.sv | 204 ++++++++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave.
//
// Word-organised memory behind an AHB-Lite slave port. OKAY transfers take
// WAIT_STATES wait cycles before the completing cycle. Illegal accesses get
// the two-cycle ERROR response. All bus outputs are decoded from registers
// only.
//
// Parameters
//   MEM_DEPTH    number of 32-bit words (byte capacity MEM_DEPTH*4)
//   REGION_BITS  number of low HADDR bits used as the local byte offset
//   WAIT_STATES  wait cycles in every OKAY data phase (0..15)
//
// Ports
//   HCLK       in   bus clock, rising edge
//   HRESET     in   synchronous active-high reset
//   HSEL       in   slave select
//   HADDR      in   byte address (only the low REGION_BITS bits are decoded)
//   HTRANS     in   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE     in   1 = write
//   HSIZE      in   000 byte, 001 halfword, 010 word
//   HWDATA     in   write data, valid in the data phase
//   HREADY     in   bus ready returned from the response multiplexer
//   HRDATA_S   out  read data (zero outside a read's completing cycle)
//   HREADYOUT  out  this slave's ready
//   HRESP_S    out  0 OKAY, 1 ERROR
module ahb_lite_sram_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int REGION_BITS = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA_S,
  output logic        HREADYOUT,
  output logic        HRESP_S
);

  localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);
  localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [1:0]       lo_q, lo_d;
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;

  logic [31:0]      mem [MEM_DEPTH];
  logic [31:0]      mem_rdata_q;
  logic             rd_valid_q;
  logic [3:0]       fwd_be_q;
  logic [31:0]      fwd_data_q;

  logic [REGION_BITS-1:0] off;
  logic             can_accept;
  logic             accept;
  logic             addr_err;
  logic [3:0]       wr_be;
  logic             commit;
  logic             unused_ok;

  assign off        = HADDR[REGION_BITS-1:0];
  assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept     = can_accept & HSEL & HREADY & HTRANS[1];
  assign unused_ok  = ^{HADDR[31:REGION_BITS], HTRANS[0]};

  // Illegal-access decode for the address phase being presented.
  always_comb begin
    addr_err = 1'b0;
    if (32'(off) >= MEM_BYTES)                   addr_err = 1'b1;
    if (HSIZE > 3'b010)                          addr_err = 1'b1;
    if ((HSIZE == 3'b001) && off[0])             addr_err = 1'b1;
    if ((HSIZE == 3'b010) && (off[1:0] != 2'b00)) addr_err = 1'b1;
  end

  // Next state. Address-phase registers only load on acceptance, so idx_d
  // doubles as the memory read address for the upcoming completing cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all present HREADYOUT=1 and can pipeline.
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = off[AW+1:2];
          lo_d    = off[1:0];
          write_d = HWRITE;
          size_d  = HSIZE[1:0];
          if (addr_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
    endcase
  end

  // Little-endian lane enables of the transfer in its completing cycle.
  always_comb begin
    case (size_q)
      2'b00:   wr_be = 4'b0001 << lo_q;
      2'b01:   wr_be = lo_q[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
  end

  // Erroring transfers never reach DATA, so they cannot write. A reset in
  // the completing cycle drops the write.
  assign commit = (state_q == S_DATA) & write_q & ~HRESET;

  // Memory array: byte-lane writes and a registered read, no reset.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
    mem_rdata_q <= mem[idx_d];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      lo_q       <= 2'b00;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      rd_valid_q <= 1'b0;
      fwd_be_q   <= 4'b0000;
      fwd_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lo_q       <= lo_d;
      write_q    <= write_d;
      size_q     <= size_d;
      rd_valid_q <= (state_d == S_DATA) & ~write_d;
      // A read sampled while a write to the same word commits would see the
      // old array contents; remember the written lanes to bypass them.
      fwd_be_q   <= (commit && (idx_q == idx_d)) ? wr_be : 4'b0000;
      fwd_data_q <= HWDATA;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign HRDATA_S[8*gi +: 8] = !rd_valid_q   ? 8'h00 :
                                   fwd_be_q[gi] ? fwd_data_q[8*gi +: 8] :
                                                  mem_rdata_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP_S   = 1'b0;
    case (state_q)
      S_WAIT:  HREADYOUT = 1'b0;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP_S   = 1'b1;
      end
      S_ERR2:  HRESP_S = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Self-checking bench for ahb_lite_sram_slave. Three instances with
// different wait-state counts each get their own master driver, reference
// memory model, expectation queue and bus monitor.
module tb_ahb_lite_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic        err;
    logic        rd;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int WS = (gi == 0) ? 1 : (gi == 1) ? 0 : 3;

      logic        srst, hsel, hwrite, hready, hreadyout, hresp;
      logic [31:0] haddr, hwdata, hrdata;
      logic [1:0]  htrans;
      logic [2:0]  hsize;

      assign hready = hreadyout;

      ahb_lite_sram_slave #(
        .MEM_DEPTH  (256),
        .REGION_BITS(12),
        .WAIT_STATES(WS)
      ) dut (
        .HCLK     (clk),
        .HRESET   (srst),
        .HSEL     (hsel),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HWRITE   (hwrite),
        .HSIZE    (hsize),
        .HWDATA   (hwdata),
        .HREADY   (hready),
        .HRDATA_S (hrdata),
        .HREADYOUT(hreadyout),
        .HRESP_S  (hresp)
      );

      exp_t        sb_q[$];
      logic [31:0] mdata  [256];
      logic [3:0]  mknown [256];
      logic [31:0] pend_wdata;
      bit          mon_en;

      function automatic bit spec_err(logic [11:0] off, logic [2:0] size);
        if (int'(off) >= 256 * 4) return 1'b1;
        if (size > 3'd2) return 1'b1;
        if (int'(off) % (1 << size) != 0) return 1'b1;
        return 1'b0;
      endfunction

      // Lanes covered by an aligned access of 2^size bytes at offset lo.
      function automatic logic [3:0] lanes(logic [1:0] lo, logic [2:0] size);
        int nb, first;
        logic [3:0] m;
        nb    = 1 << size;
        first = (int'(lo) / nb) * nb;
        m     = 4'b0000;
        for (int b = 0; b < 4; b++) begin
          if (b >= first && b < first + nb) m[b] = 1'b1;
        end
        return m;
      endfunction

      task automatic issue(bit sel, logic [1:0] trans, bit wr, logic [2:0] size,
                           logic [11:0] off, logic [31:0] wdata, bit apply);
        exp_t        e;
        bit          taken, rdy;
        int          idx, guard;
        logic [3:0]  ln;
        logic [31:0] r;
        r      = $urandom();
        hsel   = sel;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = {r[31:12], off};
        hwdata = pend_wdata;
        taken  = sel && trans[1];
        if (taken) begin
          e.err  = spec_err(off, size);
          e.rd   = !wr;
          e.data = 32'h0;
          e.mask = 32'hFFFF_FFFF;
          idx    = int'(off) / 4;
          if (!e.err && !wr) begin
            e.data = mdata[idx];
            for (int b = 0; b < 4; b++) e.mask[8*b +: 8] = {8{mknown[idx][b]}};
          end
          if (!e.err && wr && apply) begin
            ln = lanes(off[1:0], size);
            for (int b = 0; b < 4; b++) begin
              if (ln[b]) begin
                mdata[idx][8*b +: 8] = wdata[8*b +: 8];
                mknown[idx][b]       = 1'b1;
              end
            end
          end
          sb_q.push_back(e);
        end
        guard = 0;
        forever begin
          @(negedge clk);
          rdy = hready;
          @(posedge clk);
          #1;
          if (rdy) break;
          guard++;
          if (guard > 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ws%0d accept_timeout: HREADY still 0 after %0d cycles, required 1", WS, guard);
            break;
          end
        end
        pend_wdata = taken ? wdata : 32'h0;
      endtask

      task automatic idle_cycle();
        issue(1'b0, 2'b00, 1'b0, 3'd0, 12'h0, 32'h0, 1'b0);
      endtask

      // Write whose first data-phase cycle is hit by reset.
      task automatic reset_write(logic [11:0] off, logic [31:0] wdata);
        issue(1'b1, 2'b10, 1'b1, 3'd2, off, wdata, 1'b0);
        srst   = 1'b1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = wdata;
        @(posedge clk);
        #1;
        srst       = 1'b0;
        pend_wdata = 32'h0;
      endtask

      // Driver
      initial begin
        logic [11:0] off;
        logic [2:0]  size;
        logic [1:0]  tr;
        bit          wr, sel;
        int unsigned r;
        for (int i = 0; i < 256; i++) mknown[i] = 4'b0000;
        srst = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
        haddr = 32'h0; hwdata = 32'h0; pend_wdata = 32'h0; mon_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        srst   = 1'b0;
        mon_en = 1'b1;
        repeat (4) idle_cycle();
        // word write then read back
        issue(1, 2'b10, 1, 3'd2, 12'h010, 32'hDEAD_BEEF, 1);
        issue(1, 2'b10, 0, 3'd2, 12'h010, 32'h0, 1);
        // byte and halfword merges into one word
        issue(1, 2'b10, 1, 3'd2, 12'h020, 32'h0000_0000, 1);
        issue(1, 2'b10, 1, 3'd0, 12'h022, 32'h00AA_0000, 1);
        issue(1, 2'b11, 1, 3'd1, 12'h020, 32'h0000_5555, 1);
        issue(1, 2'b10, 0, 3'd2, 12'h020, 32'h0, 1);
        // error responses, and an out-of-range write must not alias
        issue(1, 2'b10, 1, 3'd2, 12'h000, 32'h1111_1111, 1);
        issue(1, 2'b10, 0, 3'd2, 12'h402, 32'h0, 1);
        issue(1, 2'b10, 1, 3'd2, 12'h400, 32'h9999_9999, 1);
        issue(1, 2'b10, 0, 3'd2, 12'h000, 32'h0, 1);
        // back-to-back write then read of the same word
        issue(1, 2'b10, 1, 3'd2, 12'h004, 32'h1234_5678, 1);
        issue(1, 2'b10, 0, 3'd2, 12'h004, 32'h0, 1);
        // reset abandons a pending write
        issue(1, 2'b10, 1, 3'd2, 12'h008, 32'h0000_0000, 1);
        idle_cycle();
        reset_write(12'h008, 32'hCAFE_F00D);
        idle_cycle();
        issue(1, 2'b10, 0, 3'd2, 12'h008, 32'h0, 1);
        // randomized traffic
        for (int k = 0; k < 200; k++) begin
          r   = $urandom_range(0, 99);
          sel = ($urandom_range(0, 9) != 0);
          tr  = (r < 10) ? 2'b00 : (r < 15) ? 2'b01 : (r < 60) ? 2'b10 : 2'b11;
          if ($urandom_range(0, 9) == 0) off = 12'($urandom_range(1024, 4095));
          else                           off = 12'($urandom_range(0, 63));
          if ($urandom_range(0, 9) == 0) size = 3'($urandom_range(3, 7));
          else                           size = 3'($urandom_range(0, 2));
          if (size <= 3'd2 && $urandom_range(0, 3) != 0)
            off = off & ~12'((1 << size) - 1);
          wr = ($urandom_range(0, 1) == 1);
          issue(sel, tr, wr, size, off, $urandom(), 1);
        end
        repeat (3) idle_cycle();
        done_cnt++;
      end

      // Monitor: checks every cycle against the head of the expectation queue.
      initial begin
        bit          in_dp;
        int          cyc, ntx;
        exp_t        cur;
        logic        w_rdy, w_resp;
        logic [31:0] w_data, w_mask;
        in_dp = 1'b0;
        cyc   = 0;
        ntx   = 0;
        cur   = '0;
        forever begin
          @(negedge clk);
          if (mon_en) begin
            w_rdy = 1'b1; w_resp = 1'b0; w_data = 32'h0; w_mask = 32'hFFFF_FFFF;
            if (in_dp) begin
              if (cur.err) begin
                w_resp = 1'b1;
                w_rdy  = (cyc >= 1);
              end else if (cyc < WS) begin
                w_rdy = 1'b0;
              end else if (cur.rd) begin
                w_data = cur.data;
                w_mask = cur.mask;
              end
            end
            n_cmp++;
            if (hreadyout !== w_rdy || hresp !== w_resp || ((hrdata ^ w_data) & w_mask) != 32'h0) begin
              n_fail++;
              $display("FAIL ws%0d %s cyc%0d: got rdy=%0b resp=%0b rdata=%08h, want rdy=%0b resp=%0b rdata=%08h mask=%08h",
                       WS, in_dp ? "data_phase" : "idle", cyc, hreadyout, hresp, hrdata,
                       w_rdy, w_resp, w_data, w_mask);
            end
            if (in_dp) begin
              if (w_rdy) begin
                ntx++;
                $display("ws%0d txn%0d %s resp=%s rdata=%08h cycles=%0d",
                         WS, ntx, cur.rd ? "rd" : "wr", cur.err ? "ERROR" : "OKAY", hrdata, cyc + 1);
                in_dp = 1'b0;
              end else begin
                cyc++;
              end
            end
            if (srst) begin
              in_dp = 1'b0;
              sb_q.delete();
            end else if (hsel && hready && htrans[1]) begin
              if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL ws%0d scoreboard_empty: accepted transfer with 0 expected, required 1", WS);
              end else begin
                cur   = sb_q.pop_front();
                in_dp = 1'b1;
                cyc   = 0;
              end
            end
          end
        end
      end
    end
  endgenerate

  initial begin
    for (int t = 0; t < 60000; t++) begin
      if (done_cnt == 3) break;
      @(posedge clk);
    end
    if (done_cnt != 3) begin
      n_cmp++;
      n_fail++;
      $display("FAIL run_timeout: %0d drivers finished, required 3", done_cnt);
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
